// File: rtl/genius_pkg.sv
// Shared definitions for the Genius memory-game engine: state codes,
// LFSR tap positions, configuracao bit indices and a counter-width helper.
package genius_pkg;

   typedef enum logic [3:0] {
      INICIAL     = 4'h0,
      GERA        = 4'h1,
      PREP_RODADA = 4'h2,
      MOSTRA      = 4'h3,
      INTERVALO   = 4'h4,
      ESPERA      = 4'h5,
      COMPARA     = 4'h6,
      PROX_RODADA = 4'h7,
      FIM_GANHOU  = 4'hA,
      FIM_TIMEOUT = 4'hD,
      FIM_PERDEU  = 4'hE
   } estado_t;

   localparam int LFSR_W     = 16;
   localparam int LFSR_TAP_A = 15;
   localparam int LFSR_TAP_B = 13;
   localparam int LFSR_TAP_C = 12;
   localparam int LFSR_TAP_D = 10;

   localparam int CFG_CURTO = 0;
   localparam int CFG_TMO   = 1;

   function automatic int f_qw(input int m);
      return (m > 1) ? $clog2(m) : 1;
   endfunction

endpackage

// File: rtl/contador_m.sv
// Modulo-M up counter with synchronous clear; fim flags the terminal count.
module contador_m
   import genius_pkg::*;
#(
   parameter int M  = 4,
   parameter int QW = f_qw(M)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          zera,
   input  logic          conta,
   output logic [QW-1:0] Q,
   output logic          fim
);

   logic [QW-1:0] r_q;

   assign Q   = r_q;
   assign fim = (r_q == QW'(M - 1));

   // count register, wraps after the terminal count
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_q <= {QW{1'b0}};
      end else if (zera) begin
         r_q <= {QW{1'b0}};
      end else if (conta) begin
         if (fim) begin
            r_q <= {QW{1'b0}};
         end else begin
            r_q <= r_q + QW'(1);
         end
      end else begin
         r_q <= r_q;
      end
   end

endmodule

// File: rtl/circuito_genius_param.sv
// Parametrised Genius sequence engine: LFSR-generated sequence, growing replay,
// per-press checking with optional timeout. Optional echo of held buttons in
// ESPERA is enabled by defining GENIUS_ECO_EN.
module circuito_genius_param
   import genius_pkg::*;
#(
   parameter int          N_BOTOES    = 4,
   parameter int          DEPTH       = 16,
   parameter int          SHOW_CYC    = 1000,
   parameter int          GAP_CYC     = 500,
   parameter int          TIMEOUT_CYC = 5000,
   parameter logic [15:0] SEED        = 16'hACE1
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        jogar,
   input  logic [N_BOTOES-1:0]         botoes,
   input  logic [1:0]                  configuracao,
   output logic [N_BOTOES-1:0]         leds,
   output logic                        pronto,
   output logic                        ganhou,
   output logic                        perdeu,
   output logic                        timeout,
   output logic [3:0]                  db_estado,
   output logic [$clog2(DEPTH)-1:0]    db_rodada,
   output logic [$clog2(N_BOTOES)-1:0] db_jogada
);

   localparam int W  = $clog2(N_BOTOES);
   localparam int DW = $clog2(DEPTH);
   localparam logic [DW-1:0] ONE_DW     = DW'(1);
   localparam logic [DW-1:0] LAST_FULL  = DW'(DEPTH - 1);
   localparam logic [DW-1:0] LAST_CURTO = DW'(DEPTH / 4 - 1);

   function automatic logic [N_BOTOES-1:0] f_onehot(input logic [W-1:0] idx);
      f_onehot = {{(N_BOTOES-1){1'b0}}, 1'b1} << idx;
   endfunction

   function automatic logic [W-1:0] f_lsb(input logic [N_BOTOES-1:0] v);
      f_lsb = {W{1'b0}};
      for (int i = N_BOTOES - 1; i >= 0; i--) begin
         if (v[i]) begin
            f_lsb = W'(i);
         end
      end
   endfunction

   estado_t               r_state, w_state_nx;
   logic [DW-1:0]         r_k, w_k_nx, r_j, w_j_nx, r_rodada, w_rodada_nx;
   logic [1:0]            r_cfg, w_cfg_nx;
   logic [N_BOTOES-1:0]   r_cap, w_cap_nx, r_botoes_prev;
   logic [W-1:0]          r_jogada, w_jogada_nx;
   logic [LFSR_W-1:0]     r_lfsr, w_lfsr_nx;
   logic [W-1:0]          r_mem [DEPTH];
   logic [N_BOTOES-1:0]   r_leds, w_leds_nx;
   logic                  r_pronto, r_ganhou, r_perdeu, r_timeout;
   logic                  w_press, w_show_fim, w_gap_fim, w_tmo_fim, w_tmo_conta;
   logic [DW-1:0]         w_last;
   logic [N_BOTOES-1:0]   w_alvo;
   logic [f_qw(SHOW_CYC)-1:0]    w_show_q;
   logic [f_qw(GAP_CYC)-1:0]     w_gap_q;
   logic [f_qw(TIMEOUT_CYC)-1:0] w_tmo_q;
   logic                  w_unused_q;

   assign w_lfsr_nx   = {r_lfsr[LFSR_W-2:0],
                         r_lfsr[LFSR_TAP_A] ^ r_lfsr[LFSR_TAP_B] ^ r_lfsr[LFSR_TAP_C] ^ r_lfsr[LFSR_TAP_D]};
   assign w_press     = (botoes != {N_BOTOES{1'b0}}) && (r_botoes_prev == {N_BOTOES{1'b0}});
   assign w_last      = r_cfg[CFG_CURTO] ? LAST_CURTO : LAST_FULL;
   assign w_alvo      = f_onehot(r_mem[r_j]);
   assign w_tmo_conta = (r_state == ESPERA) && r_cfg[CFG_TMO];
   assign w_unused_q  = ^{w_show_q, w_gap_q, w_tmo_q};

   contador_m #(.M(SHOW_CYC)) u_show (
      .clock(clock), .reset(reset),
      .zera(r_state != MOSTRA), .conta(r_state == MOSTRA),
      .Q(w_show_q), .fim(w_show_fim)
   );

   contador_m #(.M(GAP_CYC)) u_gap (
      .clock(clock), .reset(reset),
      .zera(r_state != INTERVALO), .conta(r_state == INTERVALO),
      .Q(w_gap_q), .fim(w_gap_fim)
   );

   contador_m #(.M(TIMEOUT_CYC)) u_tmo (
      .clock(clock), .reset(reset),
      .zera(r_state != ESPERA), .conta(w_tmo_conta),
      .Q(w_tmo_q), .fim(w_tmo_fim)
   );

   // next-state and datapath next values
   always_comb begin
      w_state_nx  = r_state;
      w_k_nx      = r_k;
      w_j_nx      = r_j;
      w_rodada_nx = r_rodada;
      w_cfg_nx    = r_cfg;
      w_cap_nx    = r_cap;
      w_jogada_nx = r_jogada;
      case (r_state)
         INICIAL, FIM_GANHOU, FIM_PERDEU, FIM_TIMEOUT: begin
            if (jogar) begin
               w_state_nx  = GERA;
               w_k_nx      = {DW{1'b0}};
               w_rodada_nx = {DW{1'b0}};
               w_cfg_nx    = configuracao;
            end else begin
               w_state_nx  = r_state;
            end
         end
         GERA: begin
            w_k_nx = r_k + ONE_DW;
            if (r_k == LAST_FULL) begin
               w_state_nx = PREP_RODADA;
            end else begin
               w_state_nx = GERA;
            end
         end
         PREP_RODADA: begin
            w_k_nx     = {DW{1'b0}};
            w_state_nx = MOSTRA;
         end
         MOSTRA: begin
            if (w_show_fim) begin
               w_state_nx = INTERVALO;
            end else begin
               w_state_nx = MOSTRA;
            end
         end
         INTERVALO: begin
            if (w_gap_fim) begin
               w_k_nx = r_k + ONE_DW;
               if (r_k == r_rodada) begin
                  w_state_nx = ESPERA;
                  w_j_nx     = {DW{1'b0}};
               end else begin
                  w_state_nx = MOSTRA;
               end
            end else begin
               w_state_nx = INTERVALO;
            end
         end
         ESPERA: begin
            // a press in the same cycle as expiry takes priority
            if (w_press) begin
               w_cap_nx   = botoes;
               w_state_nx = COMPARA;
            end else if (r_cfg[CFG_TMO] && w_tmo_fim) begin
               w_state_nx = FIM_TIMEOUT;
            end else begin
               w_state_nx = ESPERA;
            end
         end
         COMPARA: begin
            w_jogada_nx = f_lsb(r_cap);
            if (r_cap != w_alvo) begin
               w_state_nx = FIM_PERDEU;
            end else if (r_j != r_rodada) begin
               w_j_nx     = r_j + ONE_DW;
               w_state_nx = ESPERA;
            end else if (r_rodada == w_last) begin
               w_state_nx = FIM_GANHOU;
            end else begin
               w_state_nx = PROX_RODADA;
            end
         end
         PROX_RODADA: begin
            w_rodada_nx = r_rodada + ONE_DW;
            w_state_nx  = PREP_RODADA;
         end
         default: begin
            w_state_nx = INICIAL;
         end
      endcase
   end

   // LED pattern for the state being entered, so leds line up with db_estado
   always_comb begin
      w_leds_nx = {N_BOTOES{1'b0}};
      case (w_state_nx)
         MOSTRA: w_leds_nx = f_onehot(r_mem[w_k_nx]);
`ifdef GENIUS_ECO_EN
         ESPERA: w_leds_nx = botoes;
`else
         ESPERA: w_leds_nx = {N_BOTOES{1'b0}};
`endif
         default: w_leds_nx = {N_BOTOES{1'b0}};
      endcase
   end

   // state, datapath and output registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state       <= INICIAL;
         r_k           <= {DW{1'b0}};
         r_j           <= {DW{1'b0}};
         r_rodada      <= {DW{1'b0}};
         r_cfg         <= 2'b00;
         r_cap         <= {N_BOTOES{1'b0}};
         r_jogada      <= {W{1'b0}};
         r_lfsr        <= SEED;
         r_botoes_prev <= {N_BOTOES{1'b0}};
         r_leds        <= {N_BOTOES{1'b0}};
         r_pronto      <= 1'b0;
         r_ganhou      <= 1'b0;
         r_perdeu      <= 1'b0;
         r_timeout     <= 1'b0;
      end else begin
         r_state       <= w_state_nx;
         r_k           <= w_k_nx;
         r_j           <= w_j_nx;
         r_rodada      <= w_rodada_nx;
         r_cfg         <= w_cfg_nx;
         r_cap         <= w_cap_nx;
         r_jogada      <= w_jogada_nx;
         r_lfsr        <= (r_state == GERA) ? w_lfsr_nx : r_lfsr;
         r_botoes_prev <= botoes;
         r_leds        <= w_leds_nx;
         r_pronto      <= (w_state_nx == FIM_GANHOU) || (w_state_nx == FIM_PERDEU) ||
                          (w_state_nx == FIM_TIMEOUT);
         r_ganhou      <= (w_state_nx == FIM_GANHOU);
         r_perdeu      <= (w_state_nx == FIM_PERDEU) || (w_state_nx == FIM_TIMEOUT);
         r_timeout     <= (w_state_nx == FIM_TIMEOUT);
      end
   end

   // sequence memory, contents are don't-care until GERA fills them
   always_ff @(posedge clock) begin
      if (r_state == GERA) begin
         r_mem[r_k] <= w_lfsr_nx[W-1:0];
      end else begin
         r_mem[r_k] <= r_mem[r_k];
      end
   end

   assign leds      = r_leds;
   assign pronto    = r_pronto;
   assign ganhou    = r_ganhou;
   assign perdeu    = r_perdeu;
   assign timeout   = r_timeout;
   assign db_estado = r_state;
   assign db_rodada = r_rodada;
   assign db_jogada = r_jogada;

endmodule

// File: tb/tb_circuito_genius_param.sv
// Scoreboard bench for circuito_genius_param: a game-level reference model
// predicts shown elements and end-of-game flags; a monitor checks them.
module tb_circuito_genius_param;

   localparam int N     = 4;
   localparam int DEPTH = 4;
   localparam int SHOW  = 4;
   localparam int GAP   = 2;
   localparam int TMO   = 20;
   localparam logic [15:0] SEED = 16'hACE1;

   logic       clock = 1'b0;
   logic       reset;
   logic       jogar;
   logic [3:0] botoes;
   logic [1:0] configuracao;
   logic [3:0] leds;
   logic       pronto, ganhou, perdeu, timeout;
   logic [3:0] db_estado;
   logic [1:0] db_rodada;
   logic [1:0] db_jogada;

   circuito_genius_param #(
      .N_BOTOES(N), .DEPTH(DEPTH), .SHOW_CYC(SHOW), .GAP_CYC(GAP),
      .TIMEOUT_CYC(TMO), .SEED(SEED)
   ) dut (
      .clock(clock), .reset(reset), .jogar(jogar), .botoes(botoes),
      .configuracao(configuracao), .leds(leds), .pronto(pronto),
      .ganhou(ganhou), .perdeu(perdeu), .timeout(timeout),
      .db_estado(db_estado), .db_rodada(db_rodada), .db_jogada(db_jogada)
   );

   always #5 clock = ~clock;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [3:0]  q_show[$];
   logic [31:0] q_fim[$];
   logic [15:0] m_lfsr;
   int          seq[DEPTH];
   int          m_jog;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] fim_rec(input int est, input int g, input int p,
                                           input int t, input int rod, input int jog);
      return (est << 7) | (g << 6) | (p << 5) | (t << 4) | (rod << 2) | jog;
   endfunction

   function automatic int lowest_bit(input int v);
      for (int i = 0; i < N; i++)
         if ((v >> i) & 1) return i;
      return 0;
   endfunction

   // model sequence generation: 16-bit Fibonacci LFSR, taps 16,14,13,11
   task automatic gen_seq();
      for (int i = 0; i < DEPTH; i++) begin
         m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
         seq[i] = m_lfsr % N;
      end
   endtask

   // monitor: pops expected shows on every LED rise and expected end records on pronto rise
   initial begin
      logic [3:0]  prev_leds;
      logic        prev_pronto;
      int          lit;
      logic [31:0] exp;
      prev_leds = 4'd0; prev_pronto = 1'b0; lit = 0;
      forever begin
         @(negedge clock);
         if (!reset) begin
            prev_leds = 4'd0; prev_pronto = 1'b0; lit = 0;
         end else begin
            if (leds != 4'd0 && prev_leds == 4'd0) begin
               if (q_show.size() == 0) begin
                  check("show_unexpected", {28'd0, leds}, 32'd0);
               end else begin
                  exp = {28'd0, q_show.pop_front()};
                  check("show_value", {28'd0, leds}, exp);
               end
               lit = 1;
            end else if (leds != 4'd0) begin
               lit++;
            end else if (prev_leds != 4'd0) begin
               check("show_length", lit, SHOW);
            end
            if (pronto && !prev_pronto) begin
               if (q_fim.size() == 0) begin
                  check("end_unexpected", {20'd0, db_estado, 8'd0}, 32'd0);
               end else begin
                  exp = q_fim.pop_front();
                  check("end_record",
                        fim_rec(db_estado, ganhou, perdeu, timeout, db_rodada, db_jogada), exp);
               end
            end
            prev_leds   = leds;
            prev_pronto = pronto;
         end
      end
   end

   initial begin
      repeat (80000) @(posedge clock);
      $display("FAIL watchdog: got no end expected end");
      $fatal(1, "watchdog");
   end

   task automatic wait_estado(input logic [3:0] code);
      int n = 0;
      while (db_estado !== code && n < 3000) begin
         @(negedge clock);
         n++;
      end
      if (db_estado !== code) check("wait_estado", {28'd0, db_estado}, {28'd0, code});
   endtask

   task automatic press(input logic [3:0] v);
      @(negedge clock);
      botoes = v;
      @(negedge clock);
      botoes = 4'd0;
   endtask

   task automatic start_game(input logic [1:0] cfg);
      @(negedge clock);
      configuracao = cfg;
      jogar = 1'b1;
      gen_seq();
      @(negedge clock);
      jogar = 1'b0;
      configuracao = 2'($urandom_range(0, 3));
   endtask

   // kind: 0 win, 1 wrong press at (fr,fp), 2 timeout in round fr, 3 long idle then wrong press
   task automatic run_game(input logic [1:0] cfg, input int kind, input int fr,
                           input int fp, input logic [3:0] forced);
      int L;
      logic [3:0] good, v;
      int n;
      L = cfg[0] ? DEPTH / 4 : DEPTH;
      start_game(cfg);
      for (int r = 0; r < L; r++) begin
         for (int i = 0; i <= r; i++) q_show.push_back(4'(1 << seq[i]));
         wait_estado(4'h5);
         if (kind == 2 && r == fr) begin
            q_fim.push_back(fim_rec(4'hD, 0, 1, 1, r, m_jog));
            n = 0;
            while (!pronto && n < 100) begin
               @(negedge clock);
               n++;
            end
            check("timeout_cycles", n, TMO);
            return;
         end
         if (kind == 3 && r == fr) begin
            repeat (100) @(negedge clock);
            check("idle_estado", {28'd0, db_estado}, 32'h5);
            check("idle_pronto", {31'd0, pronto}, 32'd0);
         end
         for (int p = 0; p <= r; p++) begin
            good = 4'(1 << seq[p]);
            if ((kind == 1 || kind == 3) && r == fr && p == fp) begin
               if (forced != 4'd0) begin
                  v = forced;
               end else begin
                  v = 4'($urandom_range(1, 15));
                  while (v == good) v = 4'($urandom_range(1, 15));
               end
               m_jog = lowest_bit(v);
               q_fim.push_back(fim_rec(4'hE, 0, 1, 0, r, m_jog));
               press(v);
               return;
            end
            m_jog = seq[p];
            if (p == r && r == L - 1) q_fim.push_back(fim_rec(4'hA, 1, 0, 0, r, m_jog));
            press(good);
            if (p < r) wait_estado(4'h5);
         end
      end
   endtask

   initial begin
      logic [1:0] cfg;
      int kind, L, fr, fp, n;
      reset = 1'b0; jogar = 1'b0; botoes = 4'd0; configuracao = 2'b00;
      m_lfsr = SEED; m_jog = 0;
      repeat (3) @(negedge clock);
      check("reset_leds", {28'd0, leds}, 32'd0);
      check("reset_flags", {28'd0, pronto, ganhou, perdeu, timeout}, 32'd0);
      check("reset_db", {24'd0, db_estado, db_rodada, db_jogada}, 32'd0);
      reset = 1'b1;

      run_game(2'b00, 0, 0, 0, 4'd0);
      run_game(2'b00, 1, 1, 1, 4'd0);
      run_game(2'b10, 2, 1, 0, 4'd0);
      run_game(2'b00, 3, 0, 0, 4'd0);
      run_game(2'b00, 1, 0, 0, 4'b1100);
      run_game(2'b01, 0, 0, 0, 4'd0);

      for (int g = 0; g < 8; g++) begin
         cfg  = 2'($urandom_range(0, 3));
         L    = cfg[0] ? DEPTH / 4 : DEPTH;
         kind = $urandom_range(0, 2);
         if (kind == 2 && !cfg[1]) kind = 3;
         fr   = $urandom_range(0, L - 1);
         fp   = $urandom_range(0, fr);
         run_game(cfg, kind, fr, fp, 4'd0);
      end

      // asynchronous abort in the middle of a shown element
      start_game(2'b00);
      q_show.push_back(4'(1 << seq[0]));
      n = 0;
      while (leds == 4'd0 && n < 200) begin
         @(negedge clock);
         n++;
      end
      check("abort_saw_show", {31'd0, leds != 4'd0}, 32'd1);
      @(negedge clock);
      #2 reset = 1'b0;
      #1;
      check("abort_leds", {28'd0, leds}, 32'd0);
      check("abort_estado", {28'd0, db_estado}, 32'd0);
      q_show.delete();
      m_lfsr = SEED; m_jog = 0;
      repeat (2) @(negedge clock);
      reset = 1'b1;
      run_game(2'b00, 0, 0, 0, 4'd0);

      repeat (10) @(negedge clock);
      check("show_queue_empty", q_show.size(), 0);
      check("end_queue_empty", q_fim.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
